// File: rtl/alarm_unit_pkg.sv
// Shared time-keeping types and constants for the alarm path.
package alarm_unit_pkg;

  localparam int TIME_W   = 6;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int TMR_W    = 18;
  localparam int SNZ_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

endpackage

// File: rtl/wrap_inc_reg.sv
// Settable register that steps by one on each inc pulse and wraps to zero after MAX.
module wrap_inc_reg #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  // Next value: hold, or step with wrap at MAX.
  always_comb begin
    val_d = val_q;
    if (inc) begin
      val_d = (val_q == W'(MAX)) ? '0 : val_q + W'(1);
    end
  end

  // Value register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign value = val_q;

endmodule

// File: rtl/alarm_unit.sv
// Alarm compare plus ring/snooze sequencer driven by the time counter outputs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | armed or disarmed, waiting for a rising match
//   RINGING | buzzer active, beeping 1 s on / 1 s off, ring timer running
//   SNOOZE  | buzzer silent, snooze timer running toward a re-ring
module alarm_unit
  import alarm_unit_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              sec_tick,
  input  logic [TIME_W-1:0] sec,
  input  logic [TIME_W-1:0] min,
  input  logic [TIME_W-1:0] hour,
  input  logic              alarm_en,
  input  logic              inc_alarm_min,
  input  logic              inc_alarm_hour,
  input  logic              stop,
  input  logic              snooze,
  output logic [TIME_W-1:0] alarm_min,
  output logic [TIME_W-1:0] alarm_hour,
  output logic              ring,
  output logic              ringing,
  output logic              snoozing
);

  localparam logic [TMR_W-1:0] RING_T   = TMR_W'(RING_SECS);
  localparam logic [TMR_W-1:0] SNOOZE_T = TMR_W'(SNOOZE_SECS);
  localparam logic [SNZ_W-1:0] SNZ_MAX  = SNZ_W'(MAX_SNOOZE);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  alarm_state_t     state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
  logic             beep_q, beep_d;
  logic             match_q, match_d;
  logic             ring_q, ring_d;
  logic             ringing_q, ringing_d;
  logic             snoozing_q, snoozing_d;
  logic             trigger;
  logic             end_event;

  wrap_inc_reg #(.W(TIME_W), .MAX(MIN_MAX)) u_alarm_min (
    .clk     (clk),
    .clear_n (clear_n),
    .inc     (inc_alarm_min),
    .value   (alarm_min)
  );

  wrap_inc_reg #(.W(TIME_W), .MAX(HOUR_MAX)) u_alarm_hour (
    .clk     (clk),
    .clear_n (clear_n),
    .inc     (inc_alarm_hour),
    .value   (alarm_hour)
  );

  // Match on the alarm minute at second zero; only the rising edge triggers, so a
  // held time or a stopped alarm at the same minute cannot retrigger.
  always_comb begin
    match_d   = (hour == alarm_hour) && (min == alarm_min) && (sec == '0);
    trigger   = match_d && !match_q;
    end_event = stop || !alarm_en;
  end

  // Next-state, timer, snooze count, beep phase and registered output decode.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    snz_cnt_d = snz_cnt_q;
    beep_d    = beep_q;
    case (state_q)
      IDLE: begin
        if (trigger && alarm_en) begin
          state_d   = RINGING;
          tmr_d     = RING_T;
          snz_cnt_d = '0;
          beep_d    = 1'b1;
        end
      end
      RINGING: begin
        if (end_event) begin
          state_d = IDLE;
        end else if (snooze && (snz_cnt_q < SNZ_MAX)) begin
          state_d   = SNOOZE;
          tmr_d     = SNOOZE_T;
          snz_cnt_d = snz_cnt_q + SNZ_W'(1);
        end else if (sec_tick) begin
          // A snooze beyond the limit falls through here and the ring keeps running.
          beep_d = ~beep_q;
          if (tmr_q == TMR_ONE) begin
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q - TMR_ONE;
          end
        end
      end
      SNOOZE: begin
        if (end_event) begin
          state_d = IDLE;
        end else if (sec_tick) begin
          if (tmr_q == TMR_ONE) begin
            state_d = RINGING;
            tmr_d   = RING_T;
            beep_d  = 1'b1;
          end else begin
            tmr_d = tmr_q - TMR_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ringing_d  = (state_d == RINGING);
    snoozing_d = (state_d == SNOOZE);
    ring_d     = ringing_d && beep_d;
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      snz_cnt_q  <= '0;
      beep_q     <= 1'b0;
      match_q    <= 1'b0;
      ring_q     <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      snz_cnt_q  <= snz_cnt_d;
      beep_q     <= beep_d;
      match_q    <= match_d;
      ring_q     <= ring_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
    end
  end

  assign ring     = ring_q;
  assign ringing  = ringing_q;
  assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: alarm setting, ring/snooze timing, priorities, reset.
module tb_alarm_unit;

  logic       clk;
  logic       clear_n;
  logic       sec_tick;
  logic [5:0] sec, min, hour;
  logic       alarm_en;
  logic       inc_alarm_min, inc_alarm_hour;
  logic       stop, snooze;
  logic [5:0] alarm_min, alarm_hour;
  logic       ring, ringing, snoozing;

  int total = 0;
  int bad   = 0;

  alarm_unit dut (
    .clk            (clk),
    .clear_n        (clear_n),
    .sec_tick       (sec_tick),
    .sec            (sec),
    .min            (min),
    .hour           (hour),
    .alarm_en       (alarm_en),
    .inc_alarm_min  (inc_alarm_min),
    .inc_alarm_hour (inc_alarm_hour),
    .stop           (stop),
    .snooze         (snooze),
    .alarm_min      (alarm_min),
    .alarm_hour     (alarm_hour),
    .ring           (ring),
    .ringing        (ringing),
    .snoozing       (snoozing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = 6'(h);
    min  = 6'(m);
    sec  = 6'(s);
  endtask

  task automatic advance_time();
    if (sec == 6'd59) begin
      sec = 6'd0;
      if (min == 6'd59) begin
        min  = 6'd0;
        hour = (hour == 6'd23) ? 6'd0 : hour + 6'd1;
      end else begin
        min = min + 6'd1;
      end
    end else begin
      sec = sec + 6'd1;
    end
  endtask

  // One second: tick cycle (counter advances with it) then one quiet cycle.
  task automatic sec_step();
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
    advance_time();
    cyc();
  endtask

  task automatic pulse_min();
    inc_alarm_min = 1'b1;
    cyc();
    inc_alarm_min = 1'b0;
  endtask

  task automatic pulse_hour();
    inc_alarm_hour = 1'b1;
    cyc();
    inc_alarm_hour = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
  endtask

  // Jump to 07:29:59 and roll into 07:30:00; the alarm is ringing on return.
  task automatic trigger_alarm(input string tag);
    set_time(7, 29, 59);
    cyc();
    sec_step();
    chk(tag, int'(ringing), 1);
  endtask

  initial begin
    clear_n        = 1'b0;
    sec_tick       = 1'b0;
    alarm_en       = 1'b0;
    inc_alarm_min  = 1'b0;
    inc_alarm_hour = 1'b0;
    stop           = 1'b0;
    snooze         = 1'b0;
    set_time(12, 0, 5);
    cyc();
    cyc();
    chk("rst_ring", int'(ring), 0);
    chk("rst_ringing", int'(ringing), 0);
    chk("rst_snoozing", int'(snoozing), 0);
    chk("rst_amin", int'(alarm_min), 0);
    chk("rst_ahour", int'(alarm_hour), 0);
    clear_n = 1'b1;

    // Set 07:30
    for (int i = 0; i < 30; i++) pulse_min();
    for (int i = 0; i < 7; i++) pulse_hour();
    cyc();
    chk("set_amin", int'(alarm_min), 30);
    chk("set_ahour", int'(alarm_hour), 7);

    // Basic trigger with exact latency, beep pattern and 60-tick expiry
    alarm_en = 1'b1;
    set_time(7, 29, 59);
    cyc();
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
    advance_time();
    chk("pre_trig_ringing", int'(ringing), 0);
    cyc();
    chk("trig_ringing", int'(ringing), 1);
    chk("trig_ring", int'(ring), 1);
    sec_step();
    chk("beep_off", int'(ring), 0);
    sec_step();
    chk("beep_on", int'(ring), 1);
    for (int i = 3; i <= 59; i++) sec_step();
    chk("ring_59", int'(ringing), 1);
    sec_step();
    chk("ring_expired", int'(ringing), 0);
    chk("ring_expired_ring", int'(ring), 0);

    // Snooze three times, the fourth is ignored
    trigger_alarm("snz_trig");
    for (int n = 1; n <= 3; n++) begin
      pulse_snooze();
      chk($sformatf("snz%0d_enter", n), int'(snoozing), 1);
      chk($sformatf("snz%0d_quiet", n), int'(ring), 0);
      for (int i = 1; i <= 299; i++) sec_step();
      chk($sformatf("snz%0d_299", n), int'(snoozing), 1);
      sec_step();
      chk($sformatf("snz%0d_rering", n), int'(ringing), 1);
      chk($sformatf("snz%0d_rering_beep", n), int'(ring), 1);
    end
    pulse_snooze();
    chk("snz4_ignored_snoozing", int'(snoozing), 0);
    chk("snz4_ignored_ringing", int'(ringing), 1);
    pulse_stop();
    chk("snz_stop", int'(ringing), 0);

    // Stop beats snooze
    trigger_alarm("both_trig");
    stop   = 1'b1;
    snooze = 1'b1;
    cyc();
    stop   = 1'b0;
    snooze = 1'b0;
    chk("both_ringing", int'(ringing), 0);
    chk("both_snoozing", int'(snoozing), 0);

    // Held match gives a single trigger; no retrigger after stop until match returns
    trigger_alarm("hold_trig");
    for (int i = 0; i < 20; i++) cyc();
    chk("hold_ringing", int'(ringing), 1);
    chk("hold_ring", int'(ring), 1);
    pulse_stop();
    for (int i = 0; i < 10; i++) cyc();
    chk("hold_no_retrig", int'(ringing), 0);
    set_time(7, 29, 59);
    cyc();
    set_time(7, 30, 0);
    cyc();
    chk("jump_retrig", int'(ringing), 1);

    // Disarm during snooze
    pulse_snooze();
    chk("dis_snoozing", int'(snoozing), 1);
    alarm_en = 1'b0;
    cyc();
    chk("dis_snoozing_off", int'(snoozing), 0);
    chk("dis_ringing_off", int'(ringing), 0);
    alarm_en = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("rearm_no_trig", int'(ringing), 0);

    // Reset mid-ring, then first match at 00:00:00 triggers
    trigger_alarm("rst_trig");
    clear_n = 1'b0;
    set_time(0, 0, 0);
    cyc();
    chk("mid_rst_ring", int'(ring), 0);
    chk("mid_rst_ringing", int'(ringing), 0);
    chk("mid_rst_snoozing", int'(snoozing), 0);
    chk("mid_rst_amin", int'(alarm_min), 0);
    chk("mid_rst_ahour", int'(alarm_hour), 0);
    clear_n = 1'b1;
    cyc();
    chk("post_rst_trig", int'(ringing), 1);
    pulse_stop();
    chk("post_rst_stop", int'(ringing), 0);

    // Wrap boundaries
    set_time(12, 34, 5);
    for (int i = 0; i < 59; i++) pulse_min();
    chk("amin_59", int'(alarm_min), 59);
    pulse_min();
    chk("amin_wrap", int'(alarm_min), 0);
    chk("amin_wrap_hour", int'(alarm_hour), 0);
    for (int i = 0; i < 23; i++) pulse_hour();
    chk("ahour_23", int'(alarm_hour), 23);
    pulse_hour();
    chk("ahour_wrap", int'(alarm_hour), 0);
    inc_alarm_min  = 1'b1;
    inc_alarm_hour = 1'b1;
    cyc();
    inc_alarm_min  = 1'b0;
    inc_alarm_hour = 1'b0;
    chk("both_inc_min", int'(alarm_min), 1);
    chk("both_inc_hour", int'(alarm_hour), 1);
    chk("edits_no_ring", int'(ringing), 0);

    // Edit that lands on the current time triggers from IDLE
    set_time(1, 2, 0);
    cyc();
    chk("edit_pre", int'(ringing), 0);
    pulse_min();
    chk("edit_amin", int'(alarm_min), 2);
    chk("edit_latency", int'(ringing), 0);
    cyc();
    chk("edit_trig", int'(ringing), 1);
    pulse_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
